// File: rtl/monty_iter_pkg.sv
// rtl/monty_iter_pkg.sv - shared state type, width helpers and qH builder for the iterative Montgomery reducer
package monty_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RND,
        ST_CORR,
        ST_OUT
    } state_t;

    function automatic int calc_w(input int logq, input int logqh);
        return logq - logqh;
    endfunction

    function automatic int calc_k(input int logq);
        return 2 * logq;
    endfunction

    function automatic int calc_logt(input int logq);
        return logq + 1;
    endfunction

    function automatic int calc_cw(input int nctx);
        return (nctx > 1) ? $clog2(nctx) : 1;
    endfunction

    // qH = 2^(logqh-1) + sum of signed 2^L terms, wrapped to logqh bits
    function automatic logic [63:0] build_qh(input logic [255:0] l_vec, input logic [31:0] s_vec,
                                             input int nterm, input int logl, input int logqh);
        logic [63:0] qh;
        int e;
        qh = 64'd1 << (logqh - 1);
        for (int i = 0; i < nterm; i++) begin
            e = 0;
            for (int b = 0; b < logl; b++)
                if (l_vec[i * logl + b]) e = e | (1 << b);
            if (s_vec[i]) qh = qh - (64'd1 << e);
            else          qh = qh + (64'd1 << e);
        end
        return qh & ((64'd1 << logqh) - 64'd1);
    endfunction

endpackage

// File: rtl/montgomery_shift_round.sv
// rtl/montgomery_shift_round.sv - one combinational radix-2^W Montgomery round using shift-add m*qH
module montgomery_shift_round #(
    parameter int W     = 17,
    parameter int K     = 64,
    parameter int LOGQH = 15
) (
    input  logic [K-1:0]     acc,
    input  logic [LOGQH-1:0] qh,
    output logic [K-1:0]     acc_next
);

    logic [W-1:0] c_l;
    logic [W-1:0] m;
    logic [K-1:0] prod;

    // (acc + m*q) / 2^W with q = qH*2^W + 1; the low limb always cancels to 0 or 2^W
    always_comb begin
        c_l  = acc[W-1:0];
        m    = W'(0) - c_l;
        prod = '0;
        for (int b = 0; b < LOGQH; b++)
            if (qh[b]) prod = prod + (K'(m) << b);
        acc_next = (acc >> W) + prod + K'(c_l != '0);
    end

endmodule

// File: rtl/montgomery_shift_iter.sv
// rtl/montgomery_shift_iter.sv - multi-context iterative Montgomery reducer; MONTY_ITER_CORRECT_EN adds the correction loop
module montgomery_shift_iter
    import monty_iter_pkg::*;
#(
    parameter int LOGQ   = 32,
    parameter int LOGQH  = 15,
    parameter int ROUNDS = 2,
    parameter int NTERM  = 3,
    parameter int LOGL   = 5,
    parameter int NCTX   = 4,
`ifdef MONTY_ITER_CORRECT_EN
    parameter int MAXSUB = 3,
`endif
    parameter int TAGW   = 4,
    localparam int W     = calc_w(LOGQ, LOGQH),
    localparam int K     = calc_k(LOGQ),
    localparam int LOGT  = calc_logt(LOGQ),
    localparam int CW    = calc_cw(NCTX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [CW-1:0]         cfg_ctx,
    input  logic [NTERM*LOGL-1:0] cfg_L,
    input  logic [NTERM-1:0]      cfg_S,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [K-1:0]          in_C,
    input  logic [CW-1:0]         in_ctx,
    input  logic [TAGW-1:0]       in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LOGT-1:0]       out_T,
    output logic [TAGW-1:0]       out_tag,
    output logic                  out_ovf,
    output logic                  busy
);

    localparam int RCW = $clog2(ROUNDS + 2);
    localparam int LW  = NTERM * LOGL;

    state_t           state, state_next;
    logic [K-1:0]     acc;
    logic [K-1:0]     acc_round;
    logic [RCW-1:0]   rcnt;
    logic [LOGQH-1:0] qh_r;
    logic [LOGQH-1:0] qh_sel;
    logic [TAGW-1:0]  tag_r;
    logic             ovf_r;
    logic             last_round;

    logic [LW-1:0]    ctx_l [NCTX];
    logic [NTERM-1:0] ctx_s [NCTX];

    // Sampled before any same-edge cfg write lands, so an accept sees the old context
    assign qh_sel = LOGQH'(build_qh(256'(ctx_l[in_ctx]), 32'(ctx_s[in_ctx]), NTERM, LOGL, LOGQH));

    montgomery_shift_round #(
        .W     (W),
        .K     (K),
        .LOGQH (LOGQH)
    ) u_round (
        .acc      (acc),
        .qh       (qh_r),
        .acc_next (acc_round)
    );

    assign last_round = (rcnt == RCW'(ROUNDS - 1));

`ifdef MONTY_ITER_CORRECT_EN
    localparam int SCW = $clog2(MAXSUB + 2);

    logic [SCW-1:0] scnt;
    logic [K-1:0]   q;
    logic           ge_q;
    logic           do_sub;

    assign q      = K'({qh_r, {(W-1){1'b0}}, 1'b1});
    assign ge_q   = (acc >= q);
    assign do_sub = ge_q && (scnt < SCW'(MAXSUB));
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid) state_next = ST_RND;
`ifdef MONTY_ITER_CORRECT_EN
            ST_RND:  if (last_round) state_next = ST_CORR;
            ST_CORR: if (!do_sub) state_next = ST_OUT;
`else
            ST_RND:  if (last_round) state_next = ST_OUT;
`endif
            ST_OUT:  if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCTX; i++) begin
                ctx_l[i] <= '0;
                ctx_s[i] <= '0;
            end
        end else if (cfg_we) begin
            ctx_l[cfg_ctx] <= cfg_L;
            ctx_s[cfg_ctx] <= cfg_S;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            rcnt  <= '0;
            qh_r  <= '0;
            tag_r <= '0;
            ovf_r <= 1'b0;
`ifdef MONTY_ITER_CORRECT_EN
            scnt  <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc   <= in_C;
                        tag_r <= in_tag;
                        qh_r  <= qh_sel;
                        rcnt  <= '0;
                        ovf_r <= 1'b0;
`ifdef MONTY_ITER_CORRECT_EN
                        scnt  <= '0;
`endif
                    end
                end
                ST_RND: begin
                    acc  <= acc_round;
                    rcnt <= rcnt + RCW'(1);
`ifndef MONTY_ITER_CORRECT_EN
                    if (last_round) ovf_r <= |acc_round[K-1:LOGT];
`endif
                end
`ifdef MONTY_ITER_CORRECT_EN
                ST_CORR: begin
                    if (do_sub) begin
                        acc  <= acc - q;
                        scnt <= scnt + SCW'(1);
                    end else begin
                        ovf_r <= ge_q;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);
    assign out_T     = acc[LOGT-1:0];
    assign out_tag   = tag_r;
    assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_montgomery_shift_iter.sv
// tb/tb_montgomery_shift_iter.sv - directed-vector bench for montgomery_shift_iter
module tb_montgomery_shift_iter;

    localparam logic [14:0] L0 = {5'd0, 5'd12, 5'd13};
    localparam logic [2:0]  S0 = 3'b010;
`ifdef MONTY_ITER_CORRECT_EN
    localparam int          LAT0   = 3;
    localparam int          LAT_FF = 4;
    localparam logic [32:0] EXP_FF = 33'h0_26FF_5FFF;
`else
    localparam int          LAT0   = 2;
    localparam int          LAT_FF = 2;
    localparam logic [32:0] EXP_FF = 33'h0_C701_6000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_ctx;
    logic [14:0] cfg_L;
    logic [2:0]  cfg_S;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_C;
    logic [1:0]  in_ctx;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] out_T;
    logic [3:0]  out_tag;
    logic        out_ovf;
    logic        busy;

    logic [63:0] r_mid;
    logic [63:0] r_fin;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    montgomery_shift_iter dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ctx   (cfg_ctx),
        .cfg_L     (cfg_L),
        .cfg_S     (cfg_S),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_C      (in_C),
        .in_ctx    (in_ctx),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_T     (out_T),
        .out_tag   (out_tag),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    montgomery_shift_round #(.W(17), .K(64), .LOGQH(15)) u_r0 (
        .acc      (64'hFFFF_FFFF_FFFF_FFFF),
        .qh       (15'h5001),
        .acc_next (r_mid)
    );

    montgomery_shift_round #(.W(17), .K(64), .LOGQH(15)) u_r1 (
        .acc      (r_mid),
        .qh       (15'h5001),
        .acc_next (r_fin)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
        check({tag, "_vld_after"}, 64'(out_valid), 64'd0);
    endtask

    task automatic write_ctx(input logic [1:0] ctx, input logic [14:0] l, input logic [2:0] s);
        cfg_we  = 1'b1;
        cfg_ctx = ctx;
        cfg_L   = l;
        cfg_S   = s;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [63:0] c, input logic [1:0] ctx,
                          input logic [3:0] t, input logic [32:0] exp_t, input int exp_lat);
        int lat;
        in_valid = 1'b1;
        in_C     = c;
        in_ctx   = ctx;
        in_tag   = t;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        wait_out(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_T"}, 64'(out_T), 64'(exp_t));
        check({tag, "_tag"}, 64'(out_tag), 64'(t));
        check({tag, "_ovf"}, 64'(out_ovf), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        handshake(tag);
    endtask

    initial begin
        int lat;
        rst       = 1'b0;
        cfg_we    = 1'b0;
        cfg_ctx   = '0;
        cfg_L     = '0;
        cfg_S     = '0;
        in_valid  = 1'b0;
        in_C      = '0;
        in_ctx    = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_T", 64'(out_T), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("round_pair", r_fin, 64'h0000_0000_C701_6000);
        rst = 1'b1;

        write_ctx(2'd0, L0, S0);
        run_op("zero", 64'd0, 2'd0, 4'd3, 33'd0, LAT0);
        run_op("inv17", 64'h2_0000, 2'd0, 4'd1, 33'h0_A001_B000, LAT0);
        run_op("ones", 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 4'hA, EXP_FF, LAT_FF);

        // Result held under backpressure while the next operand waits at the input
        in_valid = 1'b1;
        in_C     = 64'd0;
        in_ctx   = 2'd0;
        in_tag   = 4'd5;
        @(posedge clk);
        #1;
        in_C   = 64'h2_0000;
        in_tag = 4'd6;
        wait_out(lat);
        check("hold_lat", 64'(lat), 64'(LAT0));
        for (int i = 0; i < 10; i++) begin
            check("hold_T", 64'(out_T), 64'd0);
            check("hold_tag", 64'(out_tag), 64'd5);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        handshake("hold");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(lat);
        check("queued_lat", 64'(lat), 64'(LAT0));
        check("queued_T", 64'(out_T), 64'h0_A001_B000);
        check("queued_tag", 64'(out_tag), 64'd6);
        handshake("queued");

        // ctx 1 is still at reset defaults (qH 0x4003) when rewritten on the accept edge
        cfg_we  = 1'b1;
        cfg_ctx = 2'd1;
        cfg_L   = L0;
        cfg_S   = S0;
        run_op("ctx1_old", 64'h2_0000, 2'd1, 4'd2, 33'h0_8005_BFFE, LAT0);
        run_op("ctx1_new", 64'h2_0000, 2'd1, 4'd4, 33'h0_A001_B000, LAT0);

        in_valid = 1'b1;
        in_C     = 64'hFFFF_FFFF_FFFF_FFFF;
        in_ctx   = 2'd0;
        in_tag   = 4'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_T", 64'(out_T), 64'd0);
        check("mid_rst_out_tag", 64'(out_tag), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        run_op("post_rst_dflt", 64'h2_0000, 2'd0, 4'd7, 33'h0_8005_BFFE, LAT0);
        write_ctx(2'd0, L0, S0);
        run_op("post_rst_ones", 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 4'd8, EXP_FF, LAT_FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/montgomery_shift_iter.md
# montgomery_shift_iter

Iterative, multi-context Montgomery reducer for shift-add-friendly moduli q = qH·2^W + 1, with qH = 2^(LOGQH-1) + Σ ±2^L_i over NTERM signed terms. It is the configurable successor to the fixed three-term pipelined shift reducer. Operands arrive over a valid/ready stream, are reduced by ROUNDS radix-2^W rounds and an optional bounded correction loop, and leave with a pass-through tag. Up to NCTX moduli are held in a runtime-writable context table.

## Interface
- LOGQ, 32, modulus width; W = LOGQ-LOGQH, K = 2·LOGQ, LOGT = LOGQ+1
- LOGQH, 15, qH width
- ROUNDS, 2, reduction rounds; R = 2^(ROUNDS·W); ROUNDS·W ≥ LOGQ required
- NTERM, 3, signed power-of-two terms in qH
- LOGL, 5, width of each term exponent
- NCTX, 4, modulus contexts; CW = max(1, $clog2(NCTX))
- MAXSUB, 3, max correction subtractions
- TAGW, 4, tag width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- cfg_we  in  1  context write strobe
- cfg_ctx  in  CW  context index
- cfg_L  in  NTERM·LOGL  exponents; term i at [i·LOGL +: LOGL]
- cfg_S  in  NTERM  term signs; 1 = subtract
- in_valid / in_ready  in / out  1  operand handshake
- in_C  in  K  operand, C < 2^K
- in_ctx  in  CW  context select
- in_tag  in  TAGW  user tag
- out_valid / out_ready  out / in  1  result handshake
- out_T  out  LOGT  result, ≡ C·R^-1 mod q
- out_tag  out  TAGW  tag of the result
- out_ovf  out  1  result not fully reduced
- busy  out  1  state ≠ IDLE

## Operation
- FSM: IDLE → RND → CORR → OUT → IDLE. in_ready = (state == IDLE). out_valid = (state == OUT).
- Accept (IDLE, in_valid): acc ← in_C; tag ← in_tag; qH ← built from ctx[in_ctx]; rcnt ← 0; → RND.
- Operand snapshot: qH is captured at accept. Later cfg writes do not affect the operation in flight.
- Same-edge cfg write and accept on the same context: the accepted operation uses the pre-write value.
- RND, one round per cycle:
  - C_L = acc[W-1:0], C_H = acc >> W, m = (2^W − C_L) mod 2^W
  - acc ← C_H + m·qH + (C_L ≠ 0), with m·qH formed by shifts and add/sub only
  - The result fits in K bits (no overflow).
  - After ROUNDS rounds → CORR.
- CORR, per cycle: if acc ≥ q and scnt < MAXSUB, then acc ← acc − q and scnt++. Otherwise → OUT with out_ovf = (acc ≥ q).
- OUT: out_T = acc[LOGT-1:0] and out_tag hold stable until out_ready. Handshake → IDLE. A new operand is never accepted in the same cycle as a result handshake.
- Config writes are accepted in every state.
- Reset (rst = 0 at an edge, any state, including mid-round) takes effect on that edge:
  - State → IDLE; acc, counters, out_tag, out_ovf cleared.
  - Every context ← L = 0, S = 0.
  - Nothing partial is emitted.
- Reset values: in_ready 1, out_valid 0, out_T 0, out_tag 0, out_ovf 0, busy 0.

## Timing
- Accept edge E → out_valid high after E + ROUNDS + nsub + 1 edges, where nsub ∈ [0, MAXSUB].
- Without correction, out_valid is high after E + ROUNDS edges.
- out_valid holds indefinitely under out_ready = 0.
- in_ready rises on the edge after the result handshake.
- Minimum period between accepts: ROUNDS + 3 cycles (corrected build).
- A context write at edge E is visible to an accept at edge E+1.

## Configuration
- MONTY_ITER_CORRECT_EN defined: the CORR state, q comparator/subtractor and scnt are present; out_ovf behaves as above.
- Not defined:
  - RND goes directly to OUT; no CORR logic is built.
  - out_T = acc[LOGT-1:0].
  - out_ovf = |acc[K-1:LOGT] (truncation flag).

## Structure
- Package monty_iter_pkg holds:
  - state enum
  - derived-width functions (W, K, LOGT, CW)
  - function build_qh(L, S) returning LOGQH bits
- Sub-module montgomery_shift_round: combinational single round (acc, qH → acc'), reused by the bench reference model.

## Test plan
Defaults throughout; ctx 0 = {L 13 +, 12 −, 0 +}, giving qH = 0x5001 and q = 0xA0020001.
- C = 0, tag 3 → out_T 0, tag 3, out_ovf 0, out_valid 3 edges after accept.
- C = 0x20000 → out_T 0xA001B000 (= 2^-17 mod q), nsub 0.
- C = 0xFFFFFFFFFFFFFFFF → rounds give 0xC7016000; one subtraction; out_T 0x26FF5FFF, latency 4 edges.
- Hold out_ready = 0 for 10 cycles during OUT → out_T/out_tag stable, in_ready 0, next accept only after handshake.
- Write ctx 1 on the accept edge of a ctx 1 operation → old qH used; the next operation uses the new qH.
- Drop rst during RND → next edge: in_ready 1, out_valid 0, contexts cleared; the following op produces the correct result.
